mux_skid_stage: RTL



---
 rtl/mux_skid_stage.sv | 78 +++++++
 1 files changed

// File: rtl/mux_skid_stage.sv
// Registered N-to-1 mux stage with enable gating and a valid/ready skid buffer.
// Ports: clk, reset (sync, active-high), in_data/sel/en/in_valid/in_ready in, flush, out_data/out_err/out_valid/out_ready out.
module mux_skid_stage #(
    parameter int WIDTH  = 16,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    en,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    logic [WIDTH-1:0] lane_data;
    logic [WIDTH-1:0] beat_data;
    logic             beat_err;
    logic [WIDTH-1:0] skid_data;
    logic             skid_err;
    logic             skid_valid;
    logic             advance;
    logic             accept;

    always_comb begin
        lane_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                lane_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Compare at 32 bits so NUM_IN == 2**SEL_W never wraps.
    assign beat_err  = 32'(sel) >= 32'(NUM_IN);
    assign beat_data = (en && !beat_err) ? lane_data : '0;

    // Ready depends only on held state, never on out_ready.
    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;
    assign advance  = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            out_data   <= '0;
            out_err    <= 1'b0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_err   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (advance) begin
            if (skid_valid) begin
                out_data   <= skid_data;
                out_err    <= skid_err;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_data  <= beat_data;
                out_err   <= beat_err;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Main is stalled: park the new beat behind it.
            skid_data  <= beat_data;
            skid_err   <= beat_err;
            skid_valid <= 1'b1;
        end
    end

endmodule
